state_activity_monitor: RTL and testbench

//  Sits directly downstream of the 3-bit sequence state machine and consumes its state bus.
//  It registers the state and flags every transition with a one-cycle pulse.
//  It measures how long the machine has dwelt in the current state, flags a stall
//  (for example the terminal self-loop in state 3) and flags illegal codes 6/7.
//  It drives a 6-LED board display: one-hot state, blinking when stalled, all-on on fault.

---
 rtl/state_activity_monitor_if.sv | 26 ++
 rtl/state_activity_monitor.sv | 114 +++++++++++
 tb/tb_state_activity_monitor.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/state_activity_monitor_if.sv
// Bundles the upstream state bus and the monitor's status outputs.
`default_nettype none

interface state_activity_monitor_if #(
   parameter int DWELL_W = 16
) ();
   logic [2:0]         state;
   logic               change_pulse;
   logic [2:0]         prev_state;
   logic [DWELL_W-1:0] dwell_count;
   logic               stuck;
   logic               illegal;
   logic [5:0]         led;

   modport master (
      output state,
      input  change_pulse, prev_state, dwell_count, stuck, illegal, led
   );

   modport slave (
      input  state,
      output change_pulse, prev_state, dwell_count, stuck, illegal, led
   );
endinterface

`default_nettype wire

// File: rtl/state_activity_monitor.sv
// Watches a 3-bit state bus: change pulses, dwell timing, stall/illegal flags, LED display.
`default_nettype none

module state_activity_monitor #(
   parameter int DWELL_W     = 16,
   parameter int STUCK_LIMIT = 1000,
   parameter int BLINK_W     = 8
) (
   input  wire logic                clk,
   input  wire logic                state_reset,
   state_activity_monitor_if.slave  mon
);

   typedef enum logic [1:0] {
      MODE_INIT  = 2'd0,
      MODE_TRACK = 2'd1,
      MODE_STUCK = 2'd2,
      MODE_FAULT = 2'd3
   } mode_t;

   localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
   localparam logic [DWELL_W-1:0] STUCK_AT  = DWELL_W'(STUCK_LIMIT - 1);

   mode_t              mode_q;
   logic [2:0]         s_q;
   logic [2:0]         prev_q;
   logic [DWELL_W-1:0] dwell_q;
   logic               change_q;
   logic               stuck_q;
   logic               illegal_q;
   logic [BLINK_W-1:0] blink_q;
   logic [5:0]         led_q;

   logic               changed_d;
   logic               bad_in_d;
   logic [DWELL_W-1:0] dwell_inc_d;
   logic [5:0]         onehot_d;
   logic [5:0]         led_d;

   always_comb begin
      changed_d   = (mon.state != s_q);
      bad_in_d    = (mon.state[2:1] == 2'b11);
      dwell_inc_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
      onehot_d    = 6'b000001 << s_q;
      led_d       = 6'b000000;
      case (mode_q)
         MODE_TRACK: led_d = onehot_d;
         MODE_STUCK: led_d = blink_q[BLINK_W-1] ? 6'b000000 : onehot_d;
         MODE_FAULT: led_d = 6'b111111;
         default:    led_d = 6'b000000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state_reset) begin
         mode_q    <= MODE_INIT;
         s_q       <= 3'd0;
         prev_q    <= 3'd0;
         dwell_q   <= '0;
         change_q  <= 1'b0;
         stuck_q   <= 1'b0;
         illegal_q <= 1'b0;
         blink_q   <= '0;
         led_q     <= 6'b000000;
      end else begin
         s_q      <= mon.state;
         blink_q  <= blink_q + 1'b1;
         change_q <= 1'b0;
         led_q    <= led_d;
         if (mode_q == MODE_INIT) begin
            // First edge only latches the bus; an illegal code still lands in FAULT.
            if (bad_in_d) begin
               mode_q    <= MODE_FAULT;
               illegal_q <= 1'b1;
            end else begin
               mode_q    <= MODE_TRACK;
            end
         end else begin
            if (changed_d) begin
               change_q <= 1'b1;
               prev_q   <= s_q;
               dwell_q  <= '0;
            end else begin
               dwell_q  <= dwell_inc_d;
            end

            if (bad_in_d) begin
               mode_q    <= MODE_FAULT;
               illegal_q <= 1'b1;
               stuck_q   <= 1'b0;
            end else if (changed_d) begin
               mode_q    <= MODE_TRACK;
               illegal_q <= 1'b0;
               stuck_q   <= 1'b0;
            end else if (mode_q == MODE_TRACK && dwell_inc_d >= STUCK_AT) begin
               // Restart the blink phase so the stall display always opens with LED on.
               mode_q  <= MODE_STUCK;
               stuck_q <= 1'b1;
               blink_q <= '0;
            end
         end
      end
   end

   assign mon.change_pulse = change_q;
   assign mon.prev_state   = prev_q;
   assign mon.dwell_count  = dwell_q;
   assign mon.stuck        = stuck_q;
   assign mon.illegal      = illegal_q;
   assign mon.led          = led_q;

endmodule

`default_nettype wire

// File: tb/tb_state_activity_monitor.sv
// Self-checking bench: directed vector table, hand sequences and randomized model comparison.
`default_nettype none

module tb_state_activity_monitor;
   localparam int DW   = 4;
   localparam int BW   = 3;
   localparam int DMAX = (1 << DW) - 1;

   logic clk = 1'b0;
   logic state_reset;
   always #5 clk = ~clk;

   state_activity_monitor_if #(.DWELL_W(DW)) bus_a ();
   state_activity_monitor_if #(.DWELL_W(DW)) bus_b ();

   state_activity_monitor #(.DWELL_W(DW), .STUCK_LIMIT(10), .BLINK_W(BW)) dut_a (
      .clk(clk), .state_reset(state_reset), .mon(bus_a.slave));
   state_activity_monitor #(.DWELL_W(DW), .STUCK_LIMIT(12), .BLINK_W(BW)) dut_b (
      .clk(clk), .state_reset(state_reset), .mon(bus_b.slave));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      int         limit;
      int         bw;
      int         dwell;
      int         blink;
      logic [2:0] s;
      logic [2:0] prev;
      logic [5:0] led;
      bit         pulse;
      bit         stuck;
      bit         ill;
      bit         in_init;
   } model_t;

   model_t ma, mb;

   typedef struct packed {
      logic       rst;
      logic [2:0] st;
      logic       pulse;
      logic [2:0] prev;
      logic [3:0] dwell;
      logic [5:0] led;
      logic       ill;
      logic       stk;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behaviour stated in terms of time since last change and the flags it implies.
   function automatic model_t mstep(input model_t m, input logic r, input logic [2:0] in);
      model_t n = m;
      if (r) begin
         n.s = 3'd0; n.prev = 3'd0; n.dwell = 0; n.blink = 0; n.led = 6'd0;
         n.pulse = 1'b0; n.stuck = 1'b0; n.ill = 1'b0; n.in_init = 1'b1;
         return n;
      end
      if (m.in_init)                                 n.led = 6'd0;
      else if (m.ill)                                n.led = 6'h3F;
      else if (m.stuck && ((m.blink >> (m.bw - 1)) & 1) == 1) n.led = 6'd0;
      else                                           n.led = 6'(1 << m.s);
      n.s   = in;
      n.ill = (in >= 3'd6);
      if (m.in_init) begin
         n.pulse = 1'b0;
         n.dwell = 0;
         n.stuck = 1'b0;
      end else begin
         n.pulse = (in != m.s);
         if (n.pulse) begin
            n.prev  = m.s;
            n.dwell = 0;
         end else begin
            n.dwell = m.dwell + 1;
         end
         n.stuck = !n.ill && (n.dwell >= m.limit - 1);
      end
      n.in_init = 1'b0;
      n.blink   = (n.stuck && !m.stuck) ? 0 : (m.blink + 1) % (1 << m.bw);
      return n;
   endfunction

   task automatic check_model(input string tag, input model_t m, input logic cp,
                              input logic [2:0] pv, input logic [DW-1:0] dw,
                              input logic sk, input logic il, input logic [5:0] ld);
      int dsat;
      dsat = (m.dwell > DMAX) ? DMAX : m.dwell;
      chk({tag, ".change_pulse"}, 32'(cp), 32'(m.pulse));
      chk({tag, ".prev_state"},   32'(pv), 32'(m.prev));
      chk({tag, ".dwell_count"},  32'(dw), dsat);
      chk({tag, ".stuck"},        32'(sk), 32'(m.stuck));
      chk({tag, ".illegal"},      32'(il), 32'(m.ill));
      chk({tag, ".led"},          32'(ld), 32'(m.led));
   endtask

   task automatic cyc(input logic r, input logic [2:0] s);
      state_reset = r;
      bus_a.state = s;
      bus_b.state = s;
      @(posedge clk);
      ma = mstep(ma, r, s);
      mb = mstep(mb, r, s);
      #1;
      check_model("A", ma, bus_a.change_pulse, bus_a.prev_state, bus_a.dwell_count,
                  bus_a.stuck, bus_a.illegal, bus_a.led);
      check_model("B", mb, bus_b.change_pulse, bus_b.prev_state, bus_b.dwell_count,
                  bus_b.stuck, bus_b.illegal, bus_b.led);
   endtask

   int         seg_len;
   logic [2:0] seg_st;
   logic       seg_rst;

   initial begin
      ma = '0; ma.limit = 10; ma.bw = BW;
      mb = '0; mb.limit = 12; mb.bw = BW;
      state_reset = 1'b1;
      bus_a.state = 3'd2;
      bus_b.state = 3'd2;

      //            rst   st    pulse prev  dwell  led    ill   stk
      tbl[0]  = '{1'b1, 3'd2, 1'b0, 3'd0, 4'd0, 6'h00, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 3'd2, 1'b0, 3'd0, 4'd0, 6'h00, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 3'd2, 1'b0, 3'd0, 4'd0, 6'h00, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 3'd2, 1'b0, 3'd0, 4'd0, 6'h00, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 3'd2, 1'b0, 3'd0, 4'd1, 6'h04, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 3'd2, 1'b0, 3'd0, 4'd2, 6'h04, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 3'd0, 1'b1, 3'd2, 4'd0, 6'h04, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 3'd0, 1'b0, 3'd2, 4'd1, 6'h01, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 3'd1, 1'b1, 3'd0, 4'd0, 6'h01, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 3'd1, 1'b0, 3'd0, 4'd1, 6'h02, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 3'd1, 1'b0, 3'd0, 4'd2, 6'h02, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 3'd2, 1'b1, 3'd1, 4'd0, 6'h02, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 3'd2, 1'b0, 3'd1, 4'd1, 6'h04, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 3'd6, 1'b1, 3'd2, 4'd0, 6'h04, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 3'd6, 1'b0, 3'd2, 4'd1, 6'h3F, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 3'd5, 1'b1, 3'd6, 4'd0, 6'h3F, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 3'd5, 1'b0, 3'd6, 4'd1, 6'h20, 1'b0, 1'b0};

      for (int i = 0; i < 17; i++) begin
         cyc(tbl[i].rst, tbl[i].st);
         chk($sformatf("tbl%0d.pulse", i), 32'(bus_a.change_pulse), 32'(tbl[i].pulse));
         chk($sformatf("tbl%0d.prev", i),  32'(bus_a.prev_state),   32'(tbl[i].prev));
         chk($sformatf("tbl%0d.dwell", i), 32'(bus_a.dwell_count),  32'(tbl[i].dwell));
         chk($sformatf("tbl%0d.led", i),   32'(bus_a.led),          32'(tbl[i].led));
         chk($sformatf("tbl%0d.ill", i),   32'(bus_a.illegal),      32'(tbl[i].ill));
         chk($sformatf("tbl%0d.stuck", i), 32'(bus_a.stuck),        32'(tbl[i].stk));
      end

      // Stall on state 3 with limit 10, blink phase, then release.
      cyc(1'b0, 3'd3);
      for (int i = 0; i < 8; i++) cyc(1'b0, 3'd3);
      chk("stall.dwell8", 32'(bus_a.dwell_count), 32'd8);
      chk("stall.pre",    32'(bus_a.stuck), 32'd0);
      cyc(1'b0, 3'd3);
      chk("stall.dwell9", 32'(bus_a.dwell_count), 32'd9);
      chk("stall.on",     32'(bus_a.stuck), 32'd1);
      for (int i = 0; i < 4; i++) cyc(1'b0, 3'd3);
      chk("stall.led_on",  32'(bus_a.led), 32'h08);
      cyc(1'b0, 3'd3);
      chk("stall.led_off", 32'(bus_a.led), 32'h00);
      cyc(1'b0, 3'd4);
      chk("release.stuck", 32'(bus_a.stuck), 32'd0);
      chk("release.pulse", 32'(bus_a.change_pulse), 32'd1);
      chk("release.prev",  32'(bus_a.prev_state), 32'd3);

      // Saturation of a 4-bit dwell counter.
      for (int i = 0; i < 40; i++) cyc(1'b0, 3'd4);
      chk("sat.dwell_b", 32'(bus_b.dwell_count), 32'd15);
      chk("sat.dwell_a", 32'(bus_a.dwell_count), 32'd15);
      chk("sat.stuck_b", 32'(bus_b.stuck), 32'd1);

      // Reset in the middle of a stall with dwell 12.
      cyc(1'b0, 3'd1);
      for (int i = 0; i < 12; i++) cyc(1'b0, 3'd1);
      chk("rst.pre_dwell", 32'(bus_b.dwell_count), 32'd12);
      chk("rst.pre_stuck", 32'(bus_b.stuck), 32'd1);
      cyc(1'b1, 3'd1);
      chk("rst.dwell", 32'(bus_b.dwell_count), 32'd0);
      chk("rst.stuck", 32'(bus_b.stuck), 32'd0);
      chk("rst.led",   32'(bus_b.led), 32'd0);
      chk("rst.prev",  32'(bus_b.prev_state), 32'd0);
      cyc(1'b0, 3'd3);
      chk("init.pulse", 32'(bus_b.change_pulse), 32'd0);
      chk("init.led",   32'(bus_b.led), 32'd0);
      cyc(1'b0, 3'd3);
      chk("track.led",  32'(bus_b.led), 32'h08);

      // Randomized holds, changes, illegal codes and occasional resets.
      for (int seg = 0; seg < 120; seg++) begin
         seg_len = $urandom_range(1, 16);
         seg_st  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
                                               : 3'($urandom_range(0, 5));
         seg_rst = ($urandom_range(0, 24) == 0);
         for (int k = 0; k < seg_len; k++) cyc(seg_rst && (k == 0), seg_st);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
